// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feed-forward convolutional encoder with selectable K (3..6), zero-tail
// frame termination and a single-entry valid/ready output register.
module conv_encoder_sys #(
    parameter int FRAME_LEN = 12,
    parameter int MAX_K     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] choose_constraint_length,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] encoded_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t           state;
    logic [MAX_K-2:0] sr;
    logic [7:0]       data_cnt;
    logic [2:0]       tail_cnt;
    logic [2:0]       k_lat;

    logic       load, accept, tail_step, tail_done, do_load, u;
    logic [2:0] k_eff;
    logic [5:0] win;

    function automatic logic [2:0] clamp_k(input logic [2:0] sel);
        logic [2:0] k;
        k = (sel < 3'd3) ? 3'd3 : sel;
        if (k > 3'(MAX_K)) k = 3'(MAX_K);
        return k;
    endfunction

    function automatic logic [5:0] gen_poly(input logic [2:0] k, input logic second);
        case (k)
            3'd3:    return second ? 6'o05 : 6'o07;
            3'd4:    return second ? 6'o17 : 6'o15;
            3'd5:    return second ? 6'o35 : 6'o23;
            default: return second ? 6'o75 : 6'o53;
        endcase
    endfunction

    // Reversing the polynomial puts the tap for delay d at bit d, matching win = {sr, u}.
    function automatic logic parity(input logic [5:0] g, input logic [2:0] k, input logic [5:0] w);
        logic [5:0] rev;
        rev = {<<{g}};
        return ^((rev >> (3'd6 - k)) & w);
    endfunction

    assign load      = !out_valid || out_ready;
    assign in_ready  = load && (state != TAIL) && !rst;
    assign accept    = in_valid && in_ready;
    assign tail_step = load && (state == TAIL);
    assign tail_done = tail_step && (tail_cnt == k_lat - 3'd2);
    assign do_load   = accept || tail_step;
    assign u         = (state == TAIL) ? 1'b0 : in_bit;
    // The first bit of a frame is encoded with the K being latched on that same edge.
    assign k_eff     = (state == IDLE) ? clamp_k(choose_constraint_length) : k_lat;

    always_comb begin
        win = '0;
        win[MAX_K-1:0] = {sr, u};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            data_cnt     <= '0;
            tail_cnt     <= '0;
            k_lat        <= 3'd3;
            out_valid    <= 1'b0;
            encoded_bits <= 2'b00;
            out_last     <= 1'b0;
        end else begin
            if (do_load) begin
                encoded_bits <= {parity(gen_poly(k_eff, 1'b0), k_eff, win),
                                 parity(gen_poly(k_eff, 1'b1), k_eff, win)};
                out_last     <= tail_done;
                out_valid    <= 1'b1;
                sr           <= tail_done ? '0 : {sr[MAX_K-3:0], u};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (accept) begin
                    k_lat    <= k_eff;
                    data_cnt <= 8'd1;
                    tail_cnt <= '0;
                    state    <= (FRAME_LEN == 1) ? TAIL : DATA;
                end
                DATA: if (accept) begin
                    if (data_cnt == 8'(FRAME_LEN - 1)) begin
                        state    <= TAIL;
                        data_cnt <= '0;
                        tail_cnt <= '0;
                    end else begin
                        data_cnt <= data_cnt + 8'd1;
                    end
                end
                TAIL: if (tail_step) begin
                    if (tail_done) begin
                        state    <= IDLE;
                        tail_cnt <= '0;
                    end else begin
                        tail_cnt <= tail_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Bench for conv_encoder_sys: directed frames plus randomized frames with random
// backpressure, scored against a convolution model of the generator polynomials.
module tb_conv_encoder_sys;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       in_bit, in_valid, in_ready;
    logic [1:0] encoded_bits;
    logic       out_valid, out_last, out_ready;
    logic       or_main, rand_bp, rnd_bit, gaps;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2:0] mon_q[$];
    int         cyc_q[$];
    logic [2:0] exp_q[$];

    assign out_ready = or_main & (rand_bp ? rnd_bit : 1'b1);

    conv_encoder_sys #(.FRAME_LEN(4), .MAX_K(6)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .choose_constraint_length(sel),
        .in_bit                  (in_bit),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .encoded_bits            (encoded_bits),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_last                (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each symbol observed valid&ready here is taken at the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_q.push_back({out_last, encoded_bits});
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: direct convolution of the frame (plus K-1 zero tail) with g0/g1.
    task automatic add_exp(input int fb[$], input int k);
        int g0, g1, n, p0, p1, ub;
        case (k)
            3:       begin g0 = 'o7;  g1 = 'o5;  end
            4:       begin g0 = 'o15; g1 = 'o17; end
            5:       begin g0 = 'o23; g1 = 'o35; end
            default: begin g0 = 'o53; g1 = 'o75; end
        endcase
        n = fb.size();
        for (int t = 0; t < n + k - 1; t++) begin
            p0 = 0;
            p1 = 0;
            for (int d = 0; d < k; d++) begin
                ub = (t - d >= 0 && t - d < n) ? fb[t - d] : 0;
                p0 ^= ((g0 >> (k - 1 - d)) & 1) & ub;
                p1 ^= ((g1 >> (k - 1 - d)) & 1) & ub;
            end
            exp_q.push_back({(t == n + k - 2) ? 1'b1 : 1'b0, 1'(p0), 1'(p1)});
        end
    endtask

    function automatic int kclamp(input int s);
        return (s < 3) ? 3 : ((s > 6) ? 6 : s);
    endfunction

    task automatic drive_bit(input int b);
        int guard;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_bit   = 1'(b);
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        check("accept_wait", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int fb[$], input int sel_first, input int sel_rest);
        for (int i = 0; i < fb.size(); i++) begin
            sel = (i == 0) ? 3'(sel_first) : 3'(sel_rest);
            drive_bit(fb[i]);
        end
    endtask

    task automatic wait_out();
        int guard = 0;
        while (mon_q.size() < exp_q.size() && guard < 600) begin
            guard++;
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        wait_out();
        check({tag, "_count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            check($sformatf("%s_sym%0d", tag, i), {29'b0, mon_q[i]}, {29'b0, exp_q[i]});
        mon_q.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        int fb[$];
        int fb2[$];
        int lit[$];
        int guard;
        int s;

        rst = 1'b1; sel = 3'd3; in_bit = 1'b0; in_valid = 1'b0;
        or_main = 1'b1; rand_bp = 1'b0; gaps = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_encoded", {30'b0, encoded_bits}, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // K=3 frame 1,0,1,1 with tail timing of in_ready
        fb = '{1, 0, 1, 1};
        lit = '{3, 2, 0, 1, 1, 7};
        foreach (lit[i]) exp_q.push_back(3'(lit[i]));
        send(fb, 3, 3);
        @(negedge clk); check("tail_in_ready0", {31'b0, in_ready}, 0);
        @(negedge clk); check("tail_in_ready1", {31'b0, in_ready}, 0);
        @(negedge clk); check("idle_in_ready", {31'b0, in_ready}, 1);
        check_out("k3_frame");

        // K=6 impulse response
        fb = '{1, 0, 0, 0};
        lit = '{3, 1, 3, 1, 2, 3, 0, 0, 4};
        foreach (lit[i]) exp_q.push_back(3'(lit[i]));
        send(fb, 6, 6);
        check_out("k6_impulse");

        // Backpressure on the second symbol
        fb = '{1, 0, 1, 1};
        add_exp(fb, 3);
        fork
            send(fb, 3, 3);
            begin
                guard = 0;
                while (mon_q.size() < 1 && guard < 100) begin
                    guard++;
                    @(negedge clk);
                    #1;
                end
                @(posedge clk); #1; or_main = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_hold_bits", {30'b0, encoded_bits}, 2);
                    check("bp_hold_valid", {31'b0, out_valid}, 1);
                    check("bp_in_ready", {31'b0, in_ready}, 0);
                end
                @(posedge clk); #1; or_main = 1'b1;
            end
        join
        check_out("bp_frame");

        // K clamp: 7 behaves as 6, 0 behaves as 3, mid-frame select change ignored
        fb = '{1, 0, 0, 0};
        add_exp(fb, 6);
        send(fb, 7, 7);
        check_out("clamp7");
        fb = '{1, 1, 0, 1};
        add_exp(fb, 3);
        send(fb, 0, 0);
        check_out("clamp0");
        fb = '{1, 0, 1, 1};
        add_exp(fb, 3);
        send(fb, 3, 6);
        check_out("sel_change");

        // Reset mid-frame
        fb = '{1, 1};
        send(fb, 5, 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_encoded", {30'b0, encoded_bits}, 0);
        check("midrst_out_last", {31'b0, out_last}, 0);
        check("midrst_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_release_in_ready", {31'b0, in_ready}, 1);
        mon_q.delete(); cyc_q.delete();
        @(posedge clk); #1;
        fb = '{1, 0, 1, 1};
        lit = '{3, 2, 0, 1, 1, 7};
        foreach (lit[i]) exp_q.push_back(3'(lit[i]));
        send(fb, 3, 3);
        check_out("after_rst");

        // Back-to-back frames
        fb  = '{1, 0, 1, 1};
        fb2 = '{1, 1, 1, 1};
        add_exp(fb, 3);
        add_exp(fb2, 3);
        send(fb, 3, 3);
        send(fb2, 3, 3);
        wait_out();
        if (mon_q.size() >= 7) begin
            check("b2b_no_gap", cyc_q[6], cyc_q[5] + 1);
            check("b2b_first_sym", {30'b0, mon_q[6][1:0]}, 3);
        end
        check_out("b2b");

        // Randomized frames, select values, input gaps and output backpressure
        gaps = 1'b1;
        rand_bp = 1'b1;
        for (int f = 0; f < 25; f++) begin
            fb.delete();
            for (int i = 0; i < 4; i++) fb.push_back(int'($urandom_range(0, 1)));
            s = int'($urandom_range(0, 7));
            add_exp(fb, kclamp(s));
            send(fb, s, int'($urandom_range(0, 7)));
            check_out($sformatf("rand%0d", f));
        end
        gaps = 1'b0;
        rand_bp = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
